// File: rtl/spi_main_ctrl_if.sv
// SPI bus between one main controller and its addressable nodes.
// The main drives clock, data-out, node index and enable; the selected node returns miso.
interface spi_main_ctrl_if #(
    parameter int SEL_W = 2
);
    logic             sclk;
    logic             mosi;
    logic             miso;
    logic             en;
    logic [SEL_W-1:0] sel;

    modport master (
        output sclk,
        output mosi,
        output sel,
        output en,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  sel,
        input  en,
        output miso
    );
endinterface

// File: rtl/spi_main_ctrl.sv
// SPI mode-0 main transfer engine: one full-duplex MSB-first word per accepted
// request, framed by a setup (LEAD) and hold (TRAIL) interval of CLK_DIV cycles each.
module spi_main_ctrl #(
    parameter  int NUM_NODES  = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int CLK_DIV    = 4,
    localparam int SEL_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEL_W-1:0]      node_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rx_data,
    spi_main_ctrl_if.master       spi
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]            state_reg;
    logic [DIV_W-1:0]      div_cnt_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-1:0] tx_sh_reg;
    logic [DATA_WIDTH-1:0] rx_sh_reg;
    logic [DATA_WIDTH-1:0] rx_data_reg;
    logic [SEL_W-1:0]      sel_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  sclk_reg;
    logic                  en_reg;
    logic                  node_ok;
    logic                  div_last;

    // When NUM_NODES fills the select field every index is addressable.
    generate
        if (NUM_NODES == (1 << SEL_W)) begin : g_all_valid
            assign node_ok = 1'b1;
        end else begin : g_range_check
            assign node_ok = (node_sel < SEL_W'(NUM_NODES));
        end
    endgenerate

    assign div_last = (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            rx_data_reg <= '0;
            sel_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            en_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    sclk_reg <= 1'b0;
                    en_reg   <= 1'b0;
                    if (start) begin
                        if (node_ok) begin
                            tx_sh_reg   <= tx_data;
                            sel_reg     <= node_sel;
                            en_reg      <= 1'b1;
                            busy_reg    <= 1'b1;
                            div_cnt_reg <= '0;
                            bit_cnt_reg <= '0;
                            state_reg   <= S_LEAD;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_LEAD: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        state_reg   <= S_XFER;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                S_XFER: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        sclk_reg    <= ~sclk_reg;
                        if (!sclk_reg) begin
                            rx_sh_reg <= {rx_sh_reg[DATA_WIDTH-2:0], spi.miso};
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            // The last bit stays on mosi through TRAIL and IDLE.
                            if (bit_cnt_reg == BIT_LAST) begin
                                state_reg <= S_TRAIL;
                            end else begin
                                tx_sh_reg <= {tx_sh_reg[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        en_reg      <= 1'b0;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_sh_reg;
                        state_reg   <= S_IDLE;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign rx_data  = rx_data_reg;
    assign spi.sclk = sclk_reg;
    assign spi.mosi = tx_sh_reg[DATA_WIDTH-1];
    assign spi.sel  = sel_reg;
    assign spi.en   = en_reg;
endmodule

// File: tb/tb_spi_main_ctrl.sv
// Self-checking bench for spi_main_ctrl: table of transfers scored at each done
// pulse, plus hand-written reset, overlap, back-to-back and invalid-node sequences.
module tb_spi_main_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] node_sel = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, err;
    logic [7:0] rx_data;

    logic       start3 = 1'b0;
    logic [1:0] node_sel3 = 2'd0;
    logic [7:0] tx_data3 = 8'h00;
    logic       busy3, done3, err3;
    logic [7:0] rx_data3;

    logic       loopback = 1'b0;
    logic [7:0] node_sh = 8'h00;

    spi_main_ctrl_if #(.SEL_W(2)) spi_bus ();
    spi_main_ctrl_if #(.SEL_W(2)) spi_bus3 ();

    assign spi_bus.miso  = loopback ? spi_bus.mosi : node_sh[7];
    assign spi_bus3.miso = 1'b0;

    spi_main_ctrl #(.NUM_NODES(4), .DATA_WIDTH(8), .CLK_DIV(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .node_sel(node_sel), .tx_data(tx_data),
        .busy(busy), .done(done), .err(err), .rx_data(rx_data), .spi(spi_bus.master)
    );

    spi_main_ctrl #(.NUM_NODES(3), .DATA_WIDTH(8), .CLK_DIV(4)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .node_sel(node_sel3), .tx_data(tx_data3),
        .busy(busy3), .done(done3), .err(err3), .rx_data(rx_data3), .spi(spi_bus3.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        logic [1:0] sel;
    } exp_t;
    exp_t sb_q[$];

    // Monitor state, sampled on the falling clk edge
    logic       busy_prev = 1'b0, sclk_prev = 1'b0, en_prev = 1'b0;
    int         acc_cyc = 0, rises = 0, n_done = 0, err_cnt = 0;
    int         last_done = 0, prev_done = 0, en_low_at = 0, last_gap = 0;
    logic [7:0] mosi_cap = 8'h00;
    logic       en_gap = 1'b0, sel_bad = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            busy_prev = 1'b0; sclk_prev = 1'b0; en_prev = 1'b0;
            rises = 0; en_gap = 1'b0; sel_bad = 1'b0;
        end else begin
            if (busy && !busy_prev) begin
                acc_cyc = cyc; rises = 0; mosi_cap = 8'h00; en_gap = 1'b0; sel_bad = 1'b0;
            end
            if (busy && !spi_bus.en) en_gap = 1'b1;
            if (spi_bus.sclk && !sclk_prev) begin
                rises = rises + 1;
                mosi_cap = {mosi_cap[6:0], spi_bus.mosi};
                if (sb_q.size() > 0 && spi_bus.sel != sb_q[0].sel) sel_bad = 1'b1;
            end
            // Mode-0 node: next bit presented after each falling sclk
            if (sclk_prev && !spi_bus.sclk) node_sh = {node_sh[6:0], 1'b0};
            if (!spi_bus.en && en_prev) en_low_at = cyc;
            if (spi_bus.en && !en_prev) last_gap = cyc - en_low_at;
            if (err) err_cnt = err_cnt + 1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("mosi_bits", 32'(mosi_cap), 32'(e.tx));
                    chk("latency", 32'(cyc - acc_cyc), 32'd72);
                    chk("sclk_rises", 32'(rises), 32'd8);
                    chk("en_gap", 32'(en_gap), 32'd0);
                    chk("sel_during", 32'(sel_bad), 32'd0);
                    chk("sel_value", 32'(spi_bus.sel), 32'(e.sel));
                    chk("mosi_last", 32'(spi_bus.mosi), 32'(e.tx[0]));
                    chk("busy_done", 32'(busy), 32'd0);
                    chk("en_done", 32'(spi_bus.en), 32'd0);
                end
                prev_done = last_done;
                last_done = cyc;
                n_done = n_done + 1;
            end
            busy_prev = busy; sclk_prev = spi_bus.sclk; en_prev = spi_bus.en;
        end
    end

    task automatic start_xfer(input logic [7:0] tx, input logic [1:0] s,
                              input logic [7:0] node, input logic lb);
        exp_t e;
        @(negedge clk);
        tx_data = tx; node_sel = s; loopback = lb; node_sh = node; start = 1'b1;
        e.tx = tx; e.rx = lb ? tx : node; e.sel = s;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        tx_data = ~tx;
        node_sel = s + 2'd1;
    endtask

    task automatic wait_done(input int n_before, input string name);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (n_done > n_before) ok = 1'b1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] sel;
        logic [7:0] node;
        logic       lb;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int nd;
        logic ok;
        vecs[0] = '{tx: 8'hA5, sel: 2'd2, node: 8'h00, lb: 1'b1};
        vecs[1] = '{tx: 8'hC3, sel: 2'd1, node: 8'h3C, lb: 1'b0};
        vecs[2] = '{tx: 8'h00, sel: 2'd0, node: 8'hFF, lb: 1'b0};
        vecs[3] = '{tx: 8'hFF, sel: 2'd3, node: 8'h00, lb: 1'b0};
        vecs[4] = '{tx: 8'h81, sel: 2'd3, node: 8'h7E, lb: 1'b0};
        vecs[5] = '{tx: 8'h5A, sel: 2'd0, node: 8'h00, lb: 1'b1};

        // T1: reset held with start asserted
        start = 1'b1; tx_data = 8'hFF; node_sel = 2'd2;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sclk", 32'(spi_bus.sclk), 32'd0);
        chk("rst_mosi", 32'(spi_bus.mosi), 32'd0);
        chk("rst_en", 32'(spi_bus.en), 32'd0);
        chk("rst_sel", 32'(spi_bus.sel), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // T2/T3 and more: table of single transfers
        for (int i = 0; i < 6; i++) begin
            nd = n_done;
            start_xfer(vecs[i].tx, vecs[i].sel, vecs[i].node, vecs[i].lb);
            chk("busy_after_accept", 32'(busy), 32'd1);
            wait_done(nd, "done_timeout");
            $display("xfer %0d: tx=%02h sel=%0d rx=%02h", i, vecs[i].tx, vecs[i].sel, rx_data);
        end

        // T4: restart request mid-transfer is ignored
        nd = n_done;
        start_xfer(8'h3E, 2'd1, 8'h00, 1'b1);
        repeat (20) @(negedge clk);
        tx_data = 8'hFF; node_sel = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_no_err", 32'(err), 32'd0);
        wait_done(nd, "t4_done_timeout");
        repeat (90) @(negedge clk);
        chk("t4_single_done", 32'(n_done - nd), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        $display("t4: rx=%02h dones=%0d", rx_data, n_done - nd);

        // T5: start held through the done cycle gives back-to-back transfers
        begin
            exp_t e;
            nd = n_done;
            @(negedge clk);
            tx_data = 8'h96; node_sel = 2'd1; loopback = 1'b1; start = 1'b1;
            e.tx = 8'h96; e.rx = 8'h96; e.sel = 2'd1; sb_q.push_back(e);
            repeat (10) @(negedge clk);
            tx_data = 8'h69;
            e.tx = 8'h69; e.rx = 8'h69; e.sel = 2'd1; sb_q.push_back(e);
            wait_done(nd, "t5_first_timeout");
            @(negedge clk);
            start = 1'b0;
            wait_done(nd + 1, "t5_second_timeout");
            chk("t5_done_spacing", 32'(last_done - prev_done), 32'd73);
            chk("t5_en_gap", 32'(last_gap), 32'd1);
            $display("t5: spacing=%0d en_gap=%0d", last_done - prev_done, last_gap);
        end

        // T6a: invalid node on a 3-node controller
        @(negedge clk);
        node_sel3 = 2'd3; tx_data3 = 8'h11; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("t6_err", 32'(err3), 32'd1);
        chk("t6_busy", 32'(busy3), 32'd0);
        chk("t6_en", 32'(spi_bus3.en), 32'd0);
        @(negedge clk);
        chk("t6_err_pulse", 32'(err3), 32'd0);
        node_sel3 = 2'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("t6_valid_no_err", 32'(err3), 32'd0);
        chk("t6_valid_busy", 32'(busy3), 32'd1);
        $display("t6: invalid node err checked, valid node accepted");

        // T6b: asynchronous reset at bit 4 aborts the transfer
        nd = n_done;
        start_xfer(8'hE7, 2'd2, 8'h00, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (rises >= 4) ok = 1'b1;
        end
        chk("t6_bit4_timeout", 32'(ok), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_en", 32'(spi_bus.en), 32'd0);
        chk("abort_sclk", 32'(spi_bus.sclk), 32'd0);
        chk("abort_rx", 32'(rx_data), 32'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        chk("abort_no_done", 32'(n_done - nd), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("main_no_err", 32'(err_cnt), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("t6b: reset abort, dones=%0d", n_done - nd);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_chk - n_fail, n_chk);
        $fatal(1);
    end
endmodule
